// File: rtl/mem_pkg.sv
// Shared types for the RAM sequencing controller: word-address width, access size
// codes, data-side FSM states and the alignment rule.
package mem_pkg;

  localparam int RAM_AW = 12;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_MERGE,
    ST_WRITE,
    ST_DONE,
    ST_FAULT
  } state_e;

  // Halves must be even, words must be word aligned; the reserved size is never legal.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic: extracts and sign/zero-extends load data from a RAM word, and
// merges a byte/half store value into the word that was read back.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = rd_word_i[15:8];
      2'd2:    byte_sel = rd_word_i[23:16];
      2'd3:    byte_sel = rd_word_i[31:24];
      default: byte_sel = rd_word_i[7:0];
    endcase
    half_sel = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    load_o = rd_word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = rd_word_i;
    endcase
  end

  always_comb begin
    merged_o = rd_word_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd1:    merged_o = {rd_word_i[31:16], wdata_i[7:0], rd_word_i[7:0]};
          2'd2:    merged_o = {rd_word_i[31:24], wdata_i[7:0], rd_word_i[15:0]};
          2'd3:    merged_o = {wdata_i[7:0], rd_word_i[23:0]};
          default: merged_o = {rd_word_i[31:8], wdata_i[7:0]};
        endcase
      end
      SZ_HALF: merged_o = offset_i[1] ? {wdata_i[15:0], rd_word_i[15:0]}
                                      : {rd_word_i[31:16], wdata_i[15:0]};
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Sequencing controller between the core and the dual-port word RAM: data-side FSM for
// loads, word stores and read-modify-write byte/half stores, plus a gated fetch port.
module mem_controller
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_fault,
  output logic              d_busy,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  output logic              i_fault,
  output logic [RAM_AW-1:0] ram_addr_data,
  output logic [RAM_AW-1:0] ram_addr_instr,
  output logic [31:0]       ram_data_in,
  output logic              ram_write_enable,
  input  logic [31:0]       ram_addr_out,
  input  logic [31:0]       ram_instr_out,
  output state_e            dbg_state
);

  // Data handshake: d_read/d_write are sampled only while d_busy is low; every sampled
  // request yields exactly one d_done pulse, qualified by d_fault, and nothing else.
  state_e            state_q, state_d;
  logic [RAM_AW+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  size_e             size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              store_q, store_d;

  logic              i_valid_q, i_fault_q, replay_q;
  logic [RAM_AW-1:0] replay_addr_q;

  logic [31:0]       load_val, merged_val;
  size_e             req_size;
  logic [RAM_AW-1:0] fetch_word;
  logic              fetch_ok, conflict;
  logic              unused_hi;

  assign req_size  = size_e'(d_size);
  assign unused_hi = ^{d_addr[31:RAM_AW+2], i_addr[31:RAM_AW+2]};

  mem_lane_align u_align (
    .rd_word_i  (ram_addr_out),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .offset_i   (addr_q[1:0]),
    .unsigned_i (unsigned_q),
    .load_o     (load_val),
    .merged_o   (merged_val)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    store_d    = store_q;
    case (state_q)
      ST_IDLE: begin
        if (d_read || d_write) begin
          if ((d_read && d_write) || is_misaligned(req_size, d_addr[1:0])) begin
            state_d = ST_FAULT;
          end else begin
            addr_d     = d_addr[RAM_AW+1:0];
            wdata_d    = d_wdata;
            size_d     = req_size;
            unsigned_d = d_unsigned;
            store_d    = d_write;
            state_d    = (d_write && req_size == SZ_WORD) ? ST_WRITE : ST_RD_ADDR;
          end
        end
      end
      // Loads capture the read word in RD_CAP; sub-word stores capture it in MERGE.
      ST_RD_ADDR: state_d = store_q ? ST_MERGE : ST_RD_CAP;
      ST_RD_CAP: begin
        rdata_d = load_val;
        state_d = ST_DONE;
      end
      ST_MERGE: begin
        merge_d = merged_val;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign d_busy           = state_q != ST_IDLE;
  assign d_done           = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign d_fault          = state_q == ST_FAULT;
  assign d_rdata          = d_fault ? 32'd0 : rdata_q;
  assign ram_write_enable = state_q == ST_WRITE;
  assign ram_addr_data    = d_busy ? addr_q[RAM_AW+1:2] : d_addr[RAM_AW+1:2];
  assign ram_data_in      = (size_q == SZ_WORD) ? wdata_q : merge_q;
  assign dbg_state        = state_q;

  // A fetch of the word being written this cycle reads stale data; drop it and
  // re-read the same word one cycle later, ignoring i_req during the replay.
  assign fetch_word     = i_addr[RAM_AW+1:2];
  assign fetch_ok       = i_req && (i_addr[1:0] == 2'b00) && !replay_q;
  assign conflict       = fetch_ok && ram_write_enable && (fetch_word == addr_q[RAM_AW+1:2]);
  assign ram_addr_instr = replay_q ? replay_addr_q : fetch_word;
  assign i_rdata        = ram_instr_out;
  assign i_valid        = i_valid_q;
  assign i_fault        = i_fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      merge_q       <= '0;
      rdata_q       <= '0;
      size_q        <= SZ_BYTE;
      unsigned_q    <= 1'b0;
      store_q       <= 1'b0;
      i_valid_q     <= 1'b0;
      i_fault_q     <= 1'b0;
      replay_q      <= 1'b0;
      replay_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      store_q    <= store_d;
      i_valid_q  <= replay_q || (fetch_ok && !conflict);
      i_fault_q  <= i_req && !replay_q && (i_addr[1:0] != 2'b00);
      replay_q   <= conflict;
      if (conflict) replay_addr_q <= fetch_word;
    end
  end

endmodule
